game_master_fsm: RTL and testbench
==================================

// Module: game_master_fsm
// PURPOSE
//  Parametrised top-level game controller for the snake game: IDLE/PLAY/WIN/LOSE(/PAUSE).
//  Adds a configurable win score, a life counter driven by collision pulses, and button
//  edge detection. Also adds a restart path from WIN/LOSE back to IDLE.
//  Drives the state select consumed by the VGA colour mux and the snake/target controllers.
// PARAMETERS
//  SCORE_W    4  width of SCORE input
//  WIN_SCORE  3  PLAY->WIN when SCORE >= WIN_SCORE (unsigned, SCORE_W bits)
//  LIVES      3  lives loaded on IDLE->PLAY; legal range 1..2**LIVES_W-1
//  LIVES_W    2  width of LIVES_LEFT
// PORTS
//  CLK         in   1        system clock
//  RESET       in   1        synchronous, active-high
//  BTNL/BTNT/BTNR/BTND in 1  direction buttons, debounced upstream, level
//  BTNC        in   1        centre button (pause toggle, PAUSE_EN only)
//  SCORE       in   SCORE_W  current score from score counter
//  COLLISION   in   1        1-cycle pulse: snake hit wall/self
//  STATE_OUT   out  3        0=IDLE 1=PLAY 2=WIN 3=LOSE 4=PAUSE
//  LIVES_LEFT  out  LIVES_W  remaining lives
//  GAME_ACTIVE out  1        1 only in PLAY; gates snake movement
//  RESTART     out  1        1-cycle pulse: clears score/snake/target
// BEHAVIOUR
//  Reset: STATE_OUT=IDLE, LIVES_LEFT=LIVES, GAME_ACTIVE=0, RESTART=0, button history=0.
//  Edge detect: btn_prev registered each cycle; press = btn & ~btn_prev (per button).
//   Any button held through reset release counts as one press in the first cycle.
//   A held button yields exactly one press.
//  anydir = press on any of L/T/R/D. All outputs registered; transition visible 1 cycle
//   after qualifying input sample.
//  IDLE : anydir -> PLAY, LIVES_LEFT<=LIVES.
//  PLAY : priority: (1) SCORE>=WIN_SCORE -> WIN; (2) COLLISION: LIVES_LEFT==1 -> LOSE,
//         LIVES_LEFT<=0; else LIVES_LEFT<=LIVES_LEFT-1, stay PLAY; (3) PAUSE_EN and
//         BTNC press -> PAUSE.
//         Win beats collision in the same cycle; lives unchanged on win.
//  WIN  : anydir -> IDLE, RESTART=1 for that one cycle (registered with transition).
//  LOSE : same as WIN.
//  PAUSE: BTNC press -> PLAY; COLLISION and SCORE ignored; direction presses ignored.
//  Encodings 5..7: next state IDLE, LIVES_LEFT unchanged, RESTART=0.
//  LIVES_LEFT never wraps: no decrement outside PLAY, never below 0.
//  GAME_ACTIVE = (STATE_OUT==PLAY), registered alongside state.
//  RESET mid-game overrides all: next cycle IDLE, lives reloaded, no RESTART pulse.
// CONFIGURATION
//  `PAUSE_EN defined: BTNC edge detector and PAUSE state compiled in as above.
//  `PAUSE_EN undefined: BTNC ignored (port kept, unconnected internally), PAUSE
//   unreachable, state 4 treated as illegal (-> IDLE). All other behaviour identical.
// TESTING
//  RESET 2 cyc, BTNT pulse -> STATE_OUT 0->1 next cycle, LIVES_LEFT=3, GAME_ACTIVE=1.
//  PLAY, SCORE 2->3 -> STATE_OUT=2 one cycle later; BTNL press -> IDLE + RESTART 1 cyc.
//  PLAY, 3 COLLISION pulses -> LIVES 3->2->1, then STATE_OUT=3, LIVES_LEFT=0.
//  PLAY, LIVES=1, SCORE=3 and COLLISION same cycle -> WIN, LIVES_LEFT stays 1.
//  PAUSE_EN: BTNC press -> 4; COLLISION in PAUSE -> lives unchanged; BTNC -> 1.
//   Without PAUSE_EN, BTNC press -> stays 1.
//  BTNR held 20 cycles from IDLE -> single PLAY entry. RESET mid-PLAY -> IDLE, LIVES=3,
//   RESTART=0.

Source files
------------

// File: rtl/game_master_fsm.sv
// Snake game master controller: IDLE/PLAY/WIN/LOSE with lives, win score, button edges and restart pulse.
// Optional pause state (BTNC toggle) compiled in when the PAUSE_EN macro is defined.
module game_master_fsm #(
    parameter int SCORE_W   = 4,
    parameter int WIN_SCORE = 3,
    parameter int LIVES     = 3,
    parameter int LIVES_W   = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               BTNL,
    input  logic               BTNT,
    input  logic               BTNR,
    input  logic               BTND,
    input  logic               BTNC,
    input  logic [SCORE_W-1:0] SCORE,
    input  logic               COLLISION,
    output logic [2:0]         STATE_OUT,
    output logic [LIVES_W-1:0] LIVES_LEFT,
    output logic               GAME_ACTIVE,
    output logic               RESTART
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PLAY  = 3'd1;
    localparam logic [2:0] ST_WIN   = 3'd2;
    localparam logic [2:0] ST_LOSE  = 3'd3;
    localparam logic [2:0] ST_PAUSE = 3'd4;

    localparam logic [SCORE_W-1:0] WIN_THR    = SCORE_W'(WIN_SCORE);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [LIVES_W-1:0] LIFE_ONE   = LIVES_W'(1);

    logic [2:0]         state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               active_q, active_d;
    logic               restart_q, restart_d;
    logic [3:0]         dir_prev_q, dir_now;
    logic               any_dir;
    logic               c_press;

    assign dir_now = {BTND, BTNR, BTNT, BTNL};
    assign any_dir = |(dir_now & ~dir_prev_q);

`ifdef PAUSE_EN
    logic btnc_prev_q;
    assign c_press = BTNC & ~btnc_prev_q;
`else
    logic unused_btnc;
    assign unused_btnc = BTNC;
    assign c_press     = 1'b0;
`endif

    // State register; clearing the button history lets a button held through reset count once.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            lives_q    <= LIVES_INIT;
            active_q   <= 1'b0;
            restart_q  <= 1'b0;
            dir_prev_q <= 4'b0;
`ifdef PAUSE_EN
            btnc_prev_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            active_q   <= active_d;
            restart_q  <= restart_d;
            dir_prev_q <= dir_now;
`ifdef PAUSE_EN
            btnc_prev_q <= BTNC;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        case (state_q)
            ST_IDLE: begin
                if (any_dir) begin
                    state_d = ST_PLAY;
                    lives_d = LIVES_INIT;
                end
            end
            ST_PLAY: begin
                // Winning takes precedence over a simultaneous collision.
                if (SCORE >= WIN_THR) begin
                    state_d = ST_WIN;
                end else if (COLLISION) begin
                    if (lives_q <= LIFE_ONE) begin
                        state_d = ST_LOSE;
                        lives_d = '0;
                    end else begin
                        lives_d = lives_q - LIFE_ONE;
                    end
                end else if (c_press) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_WIN, ST_LOSE: begin
                if (any_dir) state_d = ST_IDLE;
            end
`ifdef PAUSE_EN
            ST_PAUSE: begin
                if (c_press) state_d = ST_PLAY;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        restart_d   = ((state_q == ST_WIN) || (state_q == ST_LOSE)) && any_dir;
        active_d    = (state_d == ST_PLAY);
        STATE_OUT   = state_q;
        LIVES_LEFT  = lives_q;
        GAME_ACTIVE = active_q;
        RESTART     = restart_q;
    end

endmodule

// File: tb/tb_game_master_fsm.sv
// Bench for game_master_fsm: vector table, hand-written corner sequences and random stimulus vs. a reference model.
module tb_game_master_fsm;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       BTNL = 1'b0, BTNT = 1'b0, BTNR = 1'b0, BTND = 1'b0, BTNC = 1'b0;
    logic [3:0] SCORE = 4'd0;
    logic       COLLISION = 1'b0;
    logic [2:0] STATE_OUT;
    logic [1:0] LIVES_LEFT;
    logic       GAME_ACTIVE;
    logic       RESTART;

    int n_checks = 0;
    int n_fail   = 0;

    game_master_fsm #(.SCORE_W(4), .WIN_SCORE(3), .LIVES(3), .LIVES_W(2)) dut (
        .CLK(CLK), .RESET(RESET),
        .BTNL(BTNL), .BTNT(BTNT), .BTNR(BTNR), .BTND(BTND), .BTNC(BTNC),
        .SCORE(SCORE), .COLLISION(COLLISION),
        .STATE_OUT(STATE_OUT), .LIVES_LEFT(LIVES_LEFT),
        .GAME_ACTIVE(GAME_ACTIVE), .RESTART(RESTART)
    );

    always #5 CLK = ~CLK;

`ifdef PAUSE_EN
    localparam bit HAS_PAUSE = 1'b1;
`else
    localparam bit HAS_PAUSE = 1'b0;
`endif

    // Reference model: game mode, lives, restart flag and last-seen button levels.
    int m_mode    = 0;
    int m_lives   = 3;
    bit m_restart = 1'b0;
    bit m_seen [5] = '{default: 1'b0};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit lv [5];
        bit newly [5];
        bit dir_hit;
        lv = '{BTNL, BTNT, BTNR, BTND, BTNC};
        if (RESET) begin
            m_mode = 0; m_lives = 3; m_restart = 1'b0;
            m_seen = '{default: 1'b0};
            return;
        end
        foreach (lv[i]) newly[i] = lv[i] && !m_seen[i];
        dir_hit = newly[0] || newly[1] || newly[2] || newly[3];
        m_restart = 1'b0;
        if (m_mode == 0) begin
            if (dir_hit) begin m_mode = 1; m_lives = 3; end
        end else if (m_mode == 1) begin
            if (int'(SCORE) >= 3) m_mode = 2;
            else if (COLLISION) begin
                m_lives = m_lives - 1;
                if (m_lives == 0) m_mode = 3;
            end else if (HAS_PAUSE && newly[4]) m_mode = 4;
        end else if (m_mode == 2 || m_mode == 3) begin
            if (dir_hit) begin m_mode = 0; m_restart = 1'b1; end
        end else if (m_mode == 4) begin
            if (newly[4]) m_mode = 1;
        end else begin
            m_mode = 0;
        end
        m_seen = lv;
    endtask

    task automatic drive(input bit rst, input bit [4:0] btn, input logic [3:0] sc, input bit coll);
        RESET = rst;
        {BTNC, BTND, BTNR, BTNT, BTNL} = btn;
        SCORE = sc;
        COLLISION = coll;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        model_update();
        check("model_state", int'(STATE_OUT), m_mode);
        check("model_lives", int'(LIVES_LEFT), m_lives);
        check("model_active", int'(GAME_ACTIVE), int'(m_mode == 1));
        check("model_restart", int'(RESTART), int'(m_restart));
    endtask

    typedef struct {
        bit       rst;
        bit [4:0] btn;   // {C, D, R, T, L}
        logic [3:0] sc;
        bit       coll;
        int       st;
        int       lv;
        bit       act;
        bit       rs;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit [4:0] btn, logic [3:0] sc, bit coll,
                                int st, int lv, bit act, bit rs);
        vec_t v;
        v.rst = rst; v.btn = btn; v.sc = sc; v.coll = coll;
        v.st = st; v.lv = lv; v.act = act; v.rs = rs;
        return v;
    endfunction

    initial begin
        int entries;
        int prev_st;
        bit [4:0] rb;

        tbl.push_back(mk(1, 5'b00000, 0, 0, 0, 3, 0, 0));  // reset
        tbl.push_back(mk(1, 5'b00000, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(0, 5'b00010, 0, 0, 1, 3, 1, 0));  // BTNT -> PLAY
        tbl.push_back(mk(0, 5'b00000, 2, 0, 1, 3, 1, 0));
        tbl.push_back(mk(0, 5'b00000, 3, 0, 2, 3, 0, 0));  // score reaches 3 -> WIN
        tbl.push_back(mk(0, 5'b00001, 3, 0, 0, 3, 0, 1));  // BTNL -> IDLE + RESTART
        tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(0, 5'b00100, 0, 0, 1, 3, 1, 0));
        tbl.push_back(mk(0, 5'b00000, 0, 1, 1, 2, 1, 0));  // collisions
        tbl.push_back(mk(0, 5'b00000, 0, 0, 1, 2, 1, 0));
        tbl.push_back(mk(0, 5'b00000, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 5'b00000, 0, 1, 3, 0, 0, 0));  // last life -> LOSE
        tbl.push_back(mk(0, 5'b00000, 0, 1, 3, 0, 0, 0));  // no decrement in LOSE
        tbl.push_back(mk(0, 5'b01000, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 5'b01000, 0, 0, 0, 0, 0, 0));  // held: no second press
        tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 5'b01000, 0, 0, 1, 3, 1, 0));  // lives reloaded
        tbl.push_back(mk(0, 5'b00000, 0, 1, 1, 2, 1, 0));
        tbl.push_back(mk(0, 5'b00000, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 5'b00000, 3, 1, 2, 1, 0, 0));  // win beats collision
        tbl.push_back(mk(0, 5'b00010, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 5'b00001, 0, 0, 1, 3, 1, 0));
        tbl.push_back(mk(1, 5'b00000, 0, 1, 0, 3, 0, 0));  // reset mid-game
        tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(1, 5'b00100, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(0, 5'b00100, 0, 0, 1, 3, 1, 0));  // held through reset counts

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].btn, tbl[i].sc, tbl[i].coll);
            tick();
            check($sformatf("vec%0d_state", i), int'(STATE_OUT), tbl[i].st);
            check($sformatf("vec%0d_lives", i), int'(LIVES_LEFT), tbl[i].lv);
            check($sformatf("vec%0d_active", i), int'(GAME_ACTIVE), int'(tbl[i].act));
            check($sformatf("vec%0d_restart", i), int'(RESTART), int'(tbl[i].rs));
        end

        // Centre button in PLAY: pause only when compiled in.
        drive(0, 5'b10000, 0, 0); tick();
        check("btnc_press_state", int'(STATE_OUT), HAS_PAUSE ? 4 : 1);
        drive(0, 5'b10000, 0, 1); tick();
        check("pause_collision_lives", int'(LIVES_LEFT), HAS_PAUSE ? 3 : 2);
        drive(0, 5'b00000, 3, 0); tick();
        check("pause_score_ignored", int'(STATE_OUT), HAS_PAUSE ? 4 : 2);
        drive(1, 5'b00000, 0, 0); tick();
        drive(0, 5'b00001, 0, 0); tick();
        drive(0, 5'b10000, 0, 0); tick();
        drive(0, 5'b00000, 0, 0); tick();
        drive(0, 5'b10000, 0, 0); tick();
        check("btnc_second_press", int'(STATE_OUT), 1);

        // BTNR held 20 cycles from IDLE: exactly one entry into PLAY.
        drive(1, 5'b00000, 0, 0); tick(); tick();
        entries = 0;
        prev_st = int'(STATE_OUT);
        for (int k = 0; k < 20; k++) begin
            drive(0, 5'b00100, (k == 10) ? 4'd3 : 4'd0, 0);
            tick();
            if (prev_st == 0 && int'(STATE_OUT) == 1) entries++;
            prev_st = int'(STATE_OUT);
        end
        check("held_btnr_entries", entries, 1);
        check("held_btnr_no_restart", int'(STATE_OUT), 2);

        // Random stimulus against the reference model.
        drive(1, 5'b00000, 0, 0); tick();
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < 5; b++) rb[b] = ($urandom % 4) == 0;
            drive(($urandom % 80) == 0, rb,
                  (($urandom % 6) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2)),
                  ($urandom % 5) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
